// File: rtl/noc_debug_pkg.sv
// Shared definitions for NoC debug/monitor blocks:
// error codes, flit classes and field widths.
package noc_debug_pkg;

  localparam int ERRw = 4;

  localparam logic [ERRw-1:0] ERR_VC_ONEHOT    = 4'd1;
  localparam logic [ERRw-1:0] ERR_HDR_IN_PCK   = 4'd2;
  localparam logic [ERRw-1:0] ERR_TAIL_IDLE    = 4'd3;
  localparam logic [ERRw-1:0] ERR_BODY_IDLE    = 4'd4;
  localparam logic [ERRw-1:0] ERR_SINGLE_ONLY  = 4'd5;
  localparam logic [ERRw-1:0] ERR_SINGLE_SHORT = 4'd6;
  localparam logic [ERRw-1:0] ERR_TOO_SHORT    = 4'd7;
  localparam logic [ERRw-1:0] ERR_TOO_LONG     = 4'd8;

  // encoding is {hdr, tail}
  typedef enum logic [1:0] {
    FLIT_B = 2'b00,
    FLIT_T = 2'b01,
    FLIT_H = 2'b10,
    FLIT_S = 2'b11
  } flit_cls_e;

  function automatic flit_cls_e flit_class(
    input logic hdr,
    input logic tail
  );
    return flit_cls_e'({hdr, tail});
  endfunction

endpackage

// File: rtl/noc_vc_pck_tracker.sv
// Per-VC packet framing state and length tracking.
// Emits this VC's error candidates for the selected flit.
module noc_vc_pck_tracker
  import noc_debug_pkg::*;
#(
  parameter int MIN_PCK_SIZE = 2,
  parameter int MAX_PCK_SIZE = 16,
  parameter int LENw = $clog2(MAX_PCK_SIZE + 1) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic sel,
  input  logic hdr,
  input  logic tail,
  output logic active,
  output logic done,
  output logic err_hdr,
  output logic err_tail_idle,
  output logic err_body_idle,
  output logic err_short,
  output logic err_long
);

  localparam logic [LENw-1:0] LEN_ONE  = LENw'(1);
  localparam logic [LENw-1:0] LEN_MAX  = LENw'(MAX_PCK_SIZE);
  localparam logic [LENw-1:0] LEN_SAT  = LENw'(MAX_PCK_SIZE + 1);
  localparam logic [LENw-1:0] LEN_MIN1 = LENw'(MIN_PCK_SIZE - 1);

  flit_cls_e cls;
  logic is_h, is_b, is_t, is_s;
  logic [LENw-1:0] len_q;
  logic [LENw-1:0] len_inc;

  assign cls  = flit_class(hdr, tail);
  assign is_h = (cls == FLIT_H);
  assign is_b = (cls == FLIT_B);
  assign is_t = (cls == FLIT_T);
  assign is_s = (cls == FLIT_S);

  assign len_inc = (len_q == LEN_SAT) ? len_q : len_q + LEN_ONE;

  assign err_hdr       = sel & active & (is_h | is_s);
  assign err_tail_idle = sel & ~active & is_t;
  assign err_body_idle = sel & ~active & is_b;
  assign err_short     = sel & active & is_t
                       & (len_q < LEN_MIN1);
  // LEN saturates past MAX, so this fires once per packet
  assign err_long      = sel & active & (is_b | is_t)
                       & (len_q == LEN_MAX);
  assign done          = sel & (is_s | (is_t & active));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      len_q  <= '0;
    end else if (sel) begin
      unique case (1'b1)
        is_h: begin
          active <= 1'b1;
          len_q  <= LEN_ONE;
        end
        is_b: begin
          if (active) len_q <= len_inc;
        end
        is_t, is_s: begin
          active <= 1'b0;
          len_q  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/noc_vc_pck_order_monitor.sv
// Per-VC packet framing monitor: error priority, sticky
// error log, active-VC view and completed-packet count.
module noc_vc_pck_order_monitor
  import noc_debug_pkg::*;
#(
  parameter int    V            = 4,
  parameter string PCK_TYPE     = "MULTI_FLIT",
  parameter int    MIN_PCK_SIZE = 2,
  parameter int    MAX_PCK_SIZE = 16,
  parameter int    CNTw         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flit_in_wr,
  input  logic            hdr_flg_in,
  input  logic            tail_flg_in,
  input  logic [V-1:0]    vc_num_in,
  input  logic            clear_err,
  output logic            err_valid,
  output logic [ERRw-1:0] err_code,
  output logic [V-1:0]    err_vc,
  output logic [7:0]      err_sticky,
  output logic [V-1:0]    active_vc,
  output logic [CNTw-1:0] pck_count
);

  localparam bit SINGLE = (PCK_TYPE == "SINGLE_FLIT");
  localparam bit MULTI_MIN = (MIN_PCK_SIZE > 1);

  logic onehot, wr_ok, is_s;
  logic [V-1:0] sel, done;
  logic [V-1:0] e_hdr, e_tidle, e_bidle;
  logic [V-1:0] e_short, e_long;
  logic [8:1] cand;
  logic [ERRw-1:0] code_n;
  logic err_n;
  logic [7:0] new_bit;

  assign onehot = (vc_num_in != '0)
                & ((vc_num_in & (vc_num_in - 1'b1)) == '0);
  assign wr_ok  = flit_in_wr & onehot;
  assign sel    = {V{wr_ok}} & vc_num_in;
  assign is_s   = hdr_flg_in & tail_flg_in;

  for (genvar i = 0; i < V; i++) begin : g_vc
    noc_vc_pck_tracker #(
      .MIN_PCK_SIZE(MIN_PCK_SIZE),
      .MAX_PCK_SIZE(MAX_PCK_SIZE)
    ) u_trk (
      .clk          (clk),
      .reset        (reset),
      .sel          (sel[i]),
      .hdr          (hdr_flg_in),
      .tail         (tail_flg_in),
      .active       (active_vc[i]),
      .done         (done[i]),
      .err_hdr      (e_hdr[i]),
      .err_tail_idle(e_tidle[i]),
      .err_body_idle(e_bidle[i]),
      .err_short    (e_short[i]),
      .err_long     (e_long[i])
    );
  end

  assign cand[1] = flit_in_wr & ~onehot;
  assign cand[2] = |e_hdr;
  assign cand[3] = |e_tidle;
  assign cand[4] = |e_bidle;
  assign cand[5] = wr_ok & SINGLE & ~is_s;
  assign cand[6] = wr_ok & MULTI_MIN & is_s;
  assign cand[7] = |e_short;
  assign cand[8] = |e_long;

  // lowest code wins
  always_comb begin
    code_n = '0;
    for (int k = 8; k >= 1; k--) begin
      if (cand[k]) code_n = ERRw'(k);
    end
  end

  assign err_n   = |cand;
  assign new_bit = err_n ? (8'd1 << (code_n - 4'd1)) : 8'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_vc     <= '0;
      err_sticky <= '0;
      pck_count  <= '0;
    end else begin
      err_valid <= err_n;
      if (err_n) begin
        err_code <= code_n;
        err_vc   <= vc_num_in;
      end
      if (clear_err) err_sticky <= new_bit;
      else err_sticky <= err_sticky | new_bit;
      pck_count <= pck_count + CNTw'(|done);
    end
  end

endmodule

// File: tb/tb_noc_vc_pck_order_monitor.sv
// Scoreboard bench for noc_vc_pck_order_monitor: directed
// scenarios then random traffic against a rule-level model.
module tb_noc_vc_pck_order_monitor;

  localparam int V = 4;
  localparam int MIN = 3;
  localparam int MAX = 4;
  localparam int CNTw = 4;
  localparam bit SINGLE = 0;

  logic clk = 0;
  logic reset = 1;
  logic flit_in_wr = 0;
  logic hdr_flg_in = 0;
  logic tail_flg_in = 0;
  logic [V-1:0] vc_num_in = '0;
  logic clear_err = 0;
  logic err_valid;
  logic [3:0] err_code;
  logic [V-1:0] err_vc;
  logic [7:0] err_sticky;
  logic [V-1:0] active_vc;
  logic [CNTw-1:0] pck_count;

  always #5 clk = ~clk;

  noc_vc_pck_order_monitor #(
    .V(V),
    .PCK_TYPE("MULTI_FLIT"),
    .MIN_PCK_SIZE(MIN),
    .MAX_PCK_SIZE(MAX),
    .CNTw(CNTw)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flit_in_wr(flit_in_wr),
    .hdr_flg_in(hdr_flg_in),
    .tail_flg_in(tail_flg_in),
    .vc_num_in(vc_num_in),
    .clear_err(clear_err),
    .err_valid(err_valid),
    .err_code(err_code),
    .err_vc(err_vc),
    .err_sticky(err_sticky),
    .active_vc(active_vc),
    .pck_count(pck_count)
  );

  typedef struct {
    logic ev;
    logic [3:0] code;
    logic [V-1:0] vc;
    logic [7:0] sticky;
    logic [V-1:0] act;
    logic [CNTw-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  bit m_act[V];
  int m_len[V];
  int m_cnt;
  int m_code;
  logic [V-1:0] m_vc;
  logic [7:0] m_sticky;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, a, x,
               $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < V; i++) begin
      m_act[i] = 0;
      m_len[i] = 0;
    end
    m_cnt = 0;
    m_code = 0;
    m_vc = '0;
    m_sticky = '0;
  endtask

  // drive one cycle and queue the outputs the rules predict
  task automatic tick(input bit wr, input bit h, input bit t,
                      input logic [V-1:0] v, input bit clr);
    int code;
    int idx;
    bit a;
    int l;
    exp_t x;
    @(negedge clk);
    flit_in_wr = wr;
    hdr_flg_in = h;
    tail_flg_in = t;
    vc_num_in = v;
    clear_err = clr;
    code = 0;
    if (wr) begin
      if ($countones(v) != 1) code = 1;
      else begin
        idx = 0;
        for (int i = 0; i < V; i++) if (v[i]) idx = i;
        a = m_act[idx];
        l = m_len[idx];
        if (a && !h && l + 1 == MAX + 1) code = 8;
        if (!h && t && a && l + 1 < MIN) code = 7;
        if (h && t && MIN > 1) code = 6;
        if (SINGLE && !(h && t)) code = 5;
        if (!h && !t && !a) code = 4;
        if (!h && t && !a) code = 3;
        if (h && a) code = 2;
        if (h && !t) begin
          m_act[idx] = 1;
          m_len[idx] = 1;
        end else if (!h && !t) begin
          if (a && l < MAX + 1) m_len[idx] = l + 1;
        end else if (h && t || a) begin
          m_act[idx] = 0;
          m_len[idx] = 0;
          m_cnt = (m_cnt + 1) % (1 << CNTw);
        end
      end
    end
    if (code != 0) begin
      m_code = code;
      m_vc = v;
    end
    if (clr) m_sticky = '0;
    if (code != 0) m_sticky[code-1] = 1'b1;
    x.ev = (code != 0);
    x.code = 4'(m_code);
    x.vc = m_vc;
    x.sticky = m_sticky;
    for (int i = 0; i < V; i++) x.act[i] = m_act[i];
    x.cnt = CNTw'(m_cnt);
    sbq.push_back(x);
  endtask

  task automatic idle();
    tick(0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    flit_in_wr = 0;
    clear_err = 0;
    #1;
    chk("rst err_valid", 32'(err_valid), 0);
    chk("rst err_code", 32'(err_code), 0);
    chk("rst err_vc", 32'(err_vc), 0);
    chk("rst err_sticky", 32'(err_sticky), 0);
    chk("rst active_vc", 32'(active_vc), 0);
    chk("rst pck_count", 32'(pck_count), 0);
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("err_valid", 32'(err_valid), 32'(e.ev));
      chk("err_code", 32'(err_code), 32'(e.code));
      chk("err_vc", 32'(err_vc), 32'(e.vc));
      chk("err_sticky", 32'(err_sticky), 32'(e.sticky));
      chk("active_vc", 32'(active_vc), 32'(e.act));
      chk("pck_count", 32'(pck_count), 32'(e.cnt));
    end
  end

  initial begin
    int r;
    bit h;
    bit t;
    logic [V-1:0] v;
    do_reset();
    // clean packet on VC1
    tick(1, 1, 0, 4'b0010, 0);
    tick(1, 0, 0, 4'b0010, 0);
    tick(1, 0, 1, 4'b0010, 0);
    idle();
    // restart on active VC0
    tick(1, 1, 0, 4'b0001, 0);
    tick(1, 1, 0, 4'b0001, 0);
    tick(0, 0, 0, '0, 1);
    // tail on idle VC2, then non-one-hot VC
    tick(1, 0, 1, 4'b0100, 0);
    tick(1, 0, 0, 4'b0011, 0);
    idle();
    // short packet then single-flit with MIN>1
    tick(1, 1, 0, 4'b0010, 0);
    tick(1, 0, 1, 4'b0010, 0);
    tick(1, 1, 1, 4'b0010, 0);
    // overlong packet on VC3
    tick(1, 1, 0, 4'b1000, 0);
    repeat (5) tick(1, 0, 0, 4'b1000, 0);
    tick(1, 0, 1, 4'b1000, 0);
    idle();
    // reset with packets open on every VC
    for (int i = 0; i < V; i++) tick(1, 1, 0, 4'(1 << i), 0);
    idle();
    do_reset();
    tick(1, 0, 0, 4'b0001, 0);
    tick(1, 0, 1, 4'b0100, 1);
    idle();
    // random traffic
    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        idle();
        do_reset();
      end
      r = $urandom_range(0, 9);
      h = (r <= 2) || (r == 9);
      t = (r == 7) || (r == 8) || (r == 9);
      if ($urandom_range(0, 9) < 9)
        v = 4'(1 << $urandom_range(0, V - 1));
      else
        v = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 9) < 8, h, t, v,
           $urandom_range(0, 19) == 0);
    end
    idle();
    for (int w = 0; w < 5 && sbq.size() > 0; w++)
      @(negedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_vc_pck_order_monitor.md
# noc_vc_pck_order_monitor

Synthesisable, parametrised per-VC packet-framing monitor for router input ports and NI injection/ejection ports. It tracks header/body/tail ordering and packet length on every VC independently. Violations are reported through registered error outputs, not simulation aborts, so the block runs on silicon and in emulation. It also enforces minimum and maximum packet size and counts completed packets.

## Interface
Parameters:
- V, 4: number of VCs; vc_num_in is one-hot of this width.
- PCK_TYPE, "MULTI_FLIT": "SINGLE_FLIT" or "MULTI_FLIT".
- MIN_PCK_SIZE, 2: minimum legal packet length in flits (≥1).
- MAX_PCK_SIZE, 16: maximum legal packet length in flits (≥MIN_PCK_SIZE).
- CNTw, 16: width of the completed-packet counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- flit_in_wr  in  1  flit valid this cycle.
- hdr_flg_in  in  1  header flag of the flit.
- tail_flg_in  in  1  tail flag of the flit.
- vc_num_in  in  V  one-hot VC of the flit.
- clear_err  in  1  clears err_sticky.
- err_valid  out  1  one-cycle pulse: the previous write violated a rule.
- err_code  out  4  code of the highest-priority violation; held until the next error.
- err_vc  out  V  vc_num_in of the offending flit; held with err_code.
- err_sticky  out  8  bit k set when code k+1 has occurred since reset or clear.
- active_vc  out  V  VCs currently inside a packet.
- pck_count  out  CNTw  completed packets, wraps modulo 2^CNTw.

## Operation
- Per-VC state: IDLE or IN_PCK, plus length counter LEN with width log2(MAX_PCK_SIZE+1)+1, saturating at MAX_PCK_SIZE+1.
- Flit classes: H = hdr&~tail, T = ~hdr&tail, B = ~hdr&~tail, S = hdr&tail.
- Error codes, in priority order (lowest number reported when several apply):
  - 1: vc_num_in not one-hot on a write. The flit is ignored and no state changes.
  - 2: H or S on an IN_PCK VC.
  - 3: T on an IDLE VC.
  - 4: B on an IDLE VC.
  - 5: non-S flit with PCK_TYPE="SINGLE_FLIT".
  - 6: S with MIN_PCK_SIZE>1.
  - 7: tail closes a packet with LEN+1 < MIN_PCK_SIZE.
  - 8: write makes LEN+1 = MAX_PCK_SIZE+1. Reported once per packet.
- State updates (VC named by vc_num_in, codes 2–8 do not block the update):
  - H: state IN_PCK, LEN=1. On an active VC this restarts the packet.
  - B on IN_PCK: LEN+1.
  - T on IN_PCK: state IDLE, LEN=0, pck_count+1.
  - S on IDLE: pck_count+1, state stays IDLE.
  - S on IN_PCK: the old packet is abandoned, pck_count+1, state IDLE.
  - T or B on IDLE: no state change.
- Only one VC is updated per cycle; other VCs hold their state.
- err_sticky: set bits OR into the register. When clear_err and a new error occur in the same cycle, the register becomes only the new error's bit.

## Timing
- All outputs are registered. Reset value of every output and every per-VC state is 0 (IDLE, LEN=0).
- Latency: err_valid, err_code, err_vc, err_sticky, active_vc, pck_count update on the clock edge that samples flit_in_wr. They are visible one cycle after the offending flit is presented.
- err_valid is high for exactly one cycle per erroneous write. Back-to-back erroneous writes produce back-to-back pulses.
- Reset asserted mid-packet returns all VCs to IDLE immediately. The first flit after reset deasserts must be H or S.
- No backpressure: the block observes only and accepts a write every cycle.
- LEN saturates and never wraps. pck_count wraps from 2^CNTw-1 to 0 without any error.

## Structure
- Shared package noc_debug_pkg holds:
  - error code localparams (ERR_VC_ONEHOT=1 … ERR_TOO_LONG=8);
  - flit-class encoding;
  - ERRw=4.
- Sub-module noc_vc_pck_tracker: one instance per VC, generate loop over V. It holds the state and LEN and emits per-VC error candidates. The top-level block does priority encoding, VC selection, the sticky register and the counter.

## Test plan
- MIN=2, MAX=4; on VC 4'b0010 send H,B,T → active_vc=4'b0010 for two cycles then 0, pck_count=1, err_valid never asserted.
- H on VC0, then H on VC0 → err_valid pulse, err_code=2, err_vc=4'b0001, LEN=1, VC0 stays active.
- T on idle VC2, then vc_num_in=4'b0011 write → codes 3 then 1 on consecutive cycles, err_sticky=8'b0000_0101.
- MIN=3; H,T on VC1 → err_code=7 and pck_count=1. Then S on VC1 → err_code=6.
- MAX=4; H,B,B,B,B,B,T on VC3 → exactly one code-8 pulse, on the fifth flit, and pck_count increments on the tail.
- Assert reset in the middle of a packet on all VCs → all outputs 0. After release, B on VC0 → code 4. clear_err in the same cycle as a code-3 error → err_sticky=8'b0000_0100.
